// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// EX-stage operand unit for the pipelined MIPS core. It resolves rs and rt
// against NFWD downstream producers, with index 0 (EX/MEM) youngest and
// highest priority. A matching producer whose data is not yet available
// (load-use) blocks the bundle and raises stall. It selects the destination
// register and registers the resolved operands into the EX/MEM boundary
// behind a valid/ready handshake.
//
// Optional feature: define EXOP_STALL_CNT_EN to add a 16-bit saturating
// stall cycle counter on output stall_cnt.
//
// Parameters:
//   DW       data width
//   AW       register address width
//   NFWD     number of forwarding producers (>= 1)
//   LINK_REG destination register for link (regdst = 2'b10)
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   in_valid / in_ready          ID/EX bundle handshake
//   in_rs_addr/in_rt_addr/in_rd_addr  register numbers
//   in_rs_data/in_rt_data        register-file read values
//   in_imm, in_alusrc            immediate and srcb select (1 = immediate)
//   in_regdst                    00 rt, 01 rd, 10 LINK_REG, 11 register 0
//   fwd_wen/fwd_addr/fwd_data/fwd_rdy  packed per-producer forwarding info
//   out_valid / out_ready        EX/MEM bundle handshake
//   out_srca/out_srcb/out_wdata  ALU A, ALU B, store data
//   out_wreg                     destination register
//   stall                        in_valid && !in_ready, holds ID/IF
//   stall_cnt                    (EXOP_STALL_CNT_EN only) stall cycle count
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NFWD     = 3,
  parameter int LINK_REG = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_rs_addr,
  input  logic [AW-1:0]        in_rt_addr,
  input  logic [AW-1:0]        in_rd_addr,
  input  logic [DW-1:0]        in_rs_data,
  input  logic [DW-1:0]        in_rt_data,
  input  logic [DW-1:0]        in_imm,
  input  logic                 in_alusrc,
  input  logic [1:0]           in_regdst,
  input  logic [NFWD-1:0]      fwd_wen,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*DW-1:0]   fwd_data,
  input  logic [NFWD-1:0]      fwd_rdy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_srca,
  output logic [DW-1:0]        out_srcb,
  output logic [DW-1:0]        out_wdata,
  output logic [AW-1:0]        out_wreg,
  output logic                 stall
`ifdef EXOP_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  typedef struct packed {
    logic          hz;
    logic [DW-1:0] val;
  } res_t;

  // Operand resolution. The loop walks from the oldest producer to the
  // youngest so the last assignment (lowest index) wins; only that producer's
  // ready bit matters, so an older ready copy never masks a younger load.
  function automatic res_t resolve(
    input logic [AW-1:0]      addr,
    input logic [DW-1:0]      rf_data,
    input logic [NFWD-1:0]    wen,
    input logic [NFWD*AW-1:0] faddr,
    input logic [NFWD*DW-1:0] fdata,
    input logic [NFWD-1:0]    frdy
  );
    res_t          r;
    logic          hit;
    logic          rdy;
    logic [DW-1:0] d;
    hit = 1'b0;
    rdy = 1'b0;
    d   = rf_data;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (wen[i] && (faddr[i*AW +: AW] == addr)) begin
        hit = 1'b1;
        rdy = frdy[i];
        d   = fdata[i*DW +: DW];
      end
    end
    // Register 0 is hardwired: never forwarded, never a hazard.
    if (addr == '0) begin
      r.val = '0;
      r.hz  = 1'b0;
    end else begin
      r.val = d;
      r.hz  = hit && !rdy;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] sel_wreg(
    input logic [1:0]    regdst,
    input logic [AW-1:0] rt,
    input logic [AW-1:0] rd
  );
    logic [AW-1:0] w;
    case (regdst)
      2'b00:   w = rt;
      2'b01:   w = rd;
      2'b10:   w = AW'(LINK_REG);
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  res_t          rs_r;
  res_t          rt_r;
  logic          hazard;
  logic          accept;
  logic [DW-1:0] srca_d;
  logic [DW-1:0] srcb_d;
  logic [DW-1:0] wdata_d;
  logic [AW-1:0] wreg_d;

  logic          vld_p1;
  logic [DW-1:0] srca_p1;
  logic [DW-1:0] srcb_p1;
  logic [DW-1:0] wdata_p1;
  logic [AW-1:0] wreg_p1;

  // ---- Stage 0: combinational resolve, hazard and handshake ----
  always_comb begin
    rs_r = resolve(in_rs_addr, in_rs_data, fwd_wen, fwd_addr, fwd_data, fwd_rdy);
    rt_r = resolve(in_rt_addr, in_rt_data, fwd_wen, fwd_addr, fwd_data, fwd_rdy);
  end

  // rt hazard counts even with alusrc=1: store data still needs rt.
  assign hazard   = rs_r.hz || rt_r.hz;
  assign in_ready = (!vld_p1 || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign stall    = in_valid && !in_ready;

  assign srca_d  = rs_r.val;
  assign wdata_d = rt_r.val;
  assign srcb_d  = in_alusrc ? in_imm : rt_r.val;
  assign wreg_d  = sel_wreg(in_regdst, in_rt_addr, in_rd_addr);

  // ---- Stage 1: EX/MEM boundary registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      srca_p1  <= '0;
      srcb_p1  <= '0;
      wdata_p1 <= '0;
      wreg_p1  <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      srca_p1  <= srca_d;
      srcb_p1  <= srcb_d;
      wdata_p1 <= wdata_d;
      wreg_p1  <= wreg_d;
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_srca  = srca_p1;
  assign out_srcb  = srcb_p1;
  assign out_wdata = wdata_p1;
  assign out_wreg  = wreg_p1;

`ifdef EXOP_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NFWD = 3;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [AW-1:0]      in_rs_addr, in_rt_addr, in_rd_addr;
  logic [DW-1:0]      in_rs_data, in_rt_data, in_imm;
  logic               in_alusrc;
  logic [1:0]         in_regdst;
  logic [NFWD-1:0]    fwd_wen;
  logic [NFWD*AW-1:0] fwd_addr;
  logic [NFWD*DW-1:0] fwd_data;
  logic [NFWD-1:0]    fwd_rdy;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_srca, out_srcb, out_wdata;
  logic [AW-1:0]      out_wreg;
  logic               stall;
`ifdef EXOP_STALL_CNT_EN
  logic [15:0]        stall_cnt;
  logic [15:0]        cnt_snap;
`endif

  ex_operand_stage #(.DW(DW), .AW(AW), .NFWD(NFWD), .LINK_REG(31)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alusrc(in_alusrc), .in_regdst(in_regdst),
    .fwd_wen(fwd_wen), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_srca(out_srca), .out_srcb(out_srcb), .out_wdata(out_wdata),
    .out_wreg(out_wreg), .stall(stall)
`ifdef EXOP_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] srca;
    logic [DW-1:0] srcb;
    logic [DW-1:0] wdata;
    logic [AW-1:0] wreg;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0;
    in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    in_alusrc  = 1'b0; in_regdst = 2'b00;
    fwd_wen    = '0; fwd_addr = '0; fwd_data = '0; fwd_rdy = '1;
  endtask

  task automatic bundle(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic [DW-1:0] rsd,
                        input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                        input logic alusrc, input logic [1:0] regdst);
    in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
    in_alusrc = alusrc; in_regdst = regdst;
    in_valid = 1'b1;
  endtask

  task automatic set_fwd(input int i, input logic wen, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rdy);
    fwd_wen[i]           = wen;
    fwd_addr[i*AW +: AW] = a;
    fwd_data[i*DW +: DW] = d;
    fwd_rdy[i]           = rdy;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] w, input logic [AW-1:0] r);
    exp_t e;
    e.srca = a; e.srcb = b; e.wdata = w; e.wreg = r;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".srca"},  64'(out_srca),  64'(e.srca));
      chk({tag, ".srcb"},  64'(out_srcb),  64'(e.srcb));
      chk({tag, ".wdata"}, 64'(out_wdata), 64'(e.wdata));
      chk({tag, ".wreg"},  64'(out_wreg),  64'(e.wreg));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    idle();
    tick(); tick();

    // Reset state
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.srca",  64'(out_srca),  64'd0);
    chk("rst.wreg",  64'(out_wreg),  64'd0);
    chk("rst.stall", 64'(stall),     64'd0);
    reset_n = 1'b1;
    tick();

    // Plain pass
    bundle(5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 2'b01);
    #1;
    chk("plain.in_ready", 64'(in_ready), 64'd1);
    chk("plain.stall",    64'(stall),    64'd0);
    push(32'h11, 32'h22, 32'h22, 5'd7);
    tick();
    check_out("plain");

    // Priority: producer 0 beats producer 1
    set_fwd(0, 1'b1, 5'd5, 32'hAAAA, 1'b1);
    set_fwd(1, 1'b1, 5'd5, 32'hBBBB, 1'b1);
    bundle(5'd5, 5'd4, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 2'b01);
    #1;
    chk("prio.stall", 64'(stall), 64'd0);
    push(32'hAAAA, 32'h22, 32'h22, 5'd7);
    tick();
    check_out("prio");

    // Younger producer not ready: stall even though producer 1 is ready
    fwd_rdy[0] = 1'b0;
    #1;
    chk("prio_hz.stall",    64'(stall),    64'd1);
    chk("prio_hz.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("prio_hz.no_accept", 64'(out_valid), 64'd0);

    // Oldest producer alone supplies rs
    fwd_wen = 3'b100;
    set_fwd(2, 1'b1, 5'd5, 32'hCCCC, 1'b1);
    #1;
    chk("old.stall", 64'(stall), 64'd0);
    push(32'hCCCC, 32'h22, 32'h22, 5'd7);
    tick();
    check_out("old");
    idle();

    // Load-use on rt, released after 2 cycles
    set_fwd(0, 1'b1, 5'd9, 32'h55, 1'b0);
    bundle(5'd3, 5'd9, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 2'b00);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lu.stall", 64'(stall), 64'd1);
      tick();
    end
    fwd_rdy[0] = 1'b1;
    #1;
    chk("lu.release", 64'(stall), 64'd0);
    push(32'h11, 32'h55, 32'h55, 5'd9);
    tick();
    check_out("lu");
    in_alusrc = 1'b1;
    in_imm    = 32'h10;
    push(32'h11, 32'h10, 32'h55, 5'd9);
    tick();
    check_out("lu_imm");
    idle();

    // Register 0 never forwarded; link destination
    set_fwd(0, 1'b1, 5'd0, 32'hFF, 1'b1);
    bundle(5'd0, 5'd4, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 2'b10);
    push(32'h0, 32'h22, 32'h22, 5'd31);
    tick();
    check_out("r0_link");
    fwd_rdy[0] = 1'b0;
    in_regdst  = 2'b11;
    #1;
    chk("r0.no_hazard", 64'(stall), 64'd0);
    push(32'h0, 32'h22, 32'h22, 5'd0);
    tick();
    check_out("r0_none");
    idle();
    tick();
    chk("drain.valid", 64'(out_valid), 64'd0);

    // Back-pressure: A held while B waits
    bundle(5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 2'b01);
    push(32'h11, 32'h22, 32'h22, 5'd7);
    tick();
    check_out("bp_a");
`ifdef EXOP_STALL_CNT_EN
    cnt_snap = stall_cnt;
`endif
    out_ready = 1'b0;
    bundle(5'd6, 5'd8, 5'd12, 32'h66, 32'h88, 32'h99, 1'b1, 2'b01);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      chk("bp.stall",    64'(stall),    64'd1);
      tick();
      chk("bp.hold_valid", 64'(out_valid), 64'd1);
      chk("bp.hold_srca",  64'(out_srca),  64'h11);
      chk("bp.hold_wreg",  64'(out_wreg),  64'd7);
    end
    out_ready = 1'b1;
    push(32'h66, 32'h99, 32'h88, 5'd12);
    tick();
    check_out("bp_b");
`ifdef EXOP_STALL_CNT_EN
    chk("bp.stall_cnt", 64'(stall_cnt - cnt_snap), 64'd3);
`endif
    idle();

    // Reset mid-operation
    out_ready = 1'b0;
    bundle(5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 2'b01);
    tick();
    idle();
    tick();
    chk("mid.pre_valid", 64'(out_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid.valid", 64'(out_valid), 64'd0);
    chk("mid.srca",  64'(out_srca),  64'd0);
    chk("mid.srcb",  64'(out_srcb),  64'd0);
    chk("mid.wdata", 64'(out_wdata), 64'd0);
    chk("mid.wreg",  64'(out_wreg),  64'd0);
`ifdef EXOP_STALL_CNT_EN
    chk("mid.stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    bundle(5'd6, 5'd4, 5'd7, 32'h66, 32'h22, 32'h0, 1'b0, 2'b01);
    push(32'h66, 32'h22, 32'h22, 5'd7);
    tick();
    check_out("post_rst");
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
